// File: rtl/wb_uart_initiator_if.sv
// Command, response and Wishbone pipelined-mode signals of the wbuart
// register-port initiator. The master modport is the initiator's view;
// the slave modport is the view of whatever sits around it (command
// source, response sink and the Wishbone responder).
interface wb_uart_initiator_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // command channel
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_we;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_data;
  logic [SEL_W-1:0]  i_cmd_sel;

  // Wishbone initiator side
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [DATA_W-1:0] o_wb_data;
  logic [SEL_W-1:0]  o_wb_sel;
  logic              i_wb_stall;
  logic              i_wb_ack;
  logic [DATA_W-1:0] i_wb_data;

  // response channel
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_err;

  // status
  logic              o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
    output o_cmd_ready,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_data,
    output o_rsp_valid, o_rsp_data, o_rsp_err,
    input  i_rsp_ready,
    output o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
    input  o_cmd_ready,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_data,
    input  o_rsp_valid, o_rsp_data, o_rsp_err,
    output i_rsp_ready,
    input  o_busy
  );
endinterface

// File: rtl/wb_uart_initiator.sv
// Single-outstanding Wishbone pipelined-mode initiator for the wbuart
// register port. One command in, one bus transaction, one response out.
// A transaction that sees no ack within TIMEOUT cycles of cyc rising is
// abandoned and reported with the error flag (TIMEOUT = 0 waits forever).
module wb_uart_initiator #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  wb_uart_initiator_if.master   bus
);

  localparam int SEL_W = DATA_W / 8;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Abort fires on the edge where the count would reach TIMEOUT, which is
  // exactly TIMEOUT edges after the one that raised cyc.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ack_ok;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] ack_data;

  // Saturating cycle counter so a disabled timeout can never wrap into a hit.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);
  // Writes return zero data; reads return whatever the responder acked with.
  assign ack_data    = we_q ? '0 : bus.i_wb_data;
  // An ack only counts once the request has been taken (stall low) or later.
  assign ack_ok      = bus.i_wb_ack &&
                       ((state_q == WAIT) || (state_q == REQ && !bus.i_wb_stall));

  // State and output registers; async reset clears every output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready is high in IDLE, so valid alone is the handshake.
        if (bus.i_cmd_valid) begin
          we_d    = bus.i_cmd_we;
          addr_d  = bus.i_cmd_addr;
          wdata_d = bus.i_cmd_data;
          sel_d   = bus.i_cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ, WAIT: begin
        cnt_d = cnt_inc;
        if (ack_ok) begin
          // Ack beats a timeout landing on the same edge.
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ack_data;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else if (state_q == REQ && !bus.i_wb_stall) begin
          // Request accepted; strobe drops, cycle held until ack.
          stb_d   = 1'b0;
          state_d = WAIT;
        end
      end

      RSP: begin
        // Response held stable until the consumer takes it.
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Ready is forced low while reset is asserted so every output reads 0.
  assign bus.o_cmd_ready = (state_q == IDLE) && !i_reset;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_wb_cyc    = cyc_q;
  assign bus.o_wb_stb    = stb_q;
  assign bus.o_wb_we     = we_q;
  assign bus.o_wb_addr   = addr_q;
  assign bus.o_wb_data   = wdata_q;
  assign bus.o_wb_sel    = sel_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_uart_initiator.sv
// Directed plus randomized bench for wb_uart_initiator. Expected bus timing
// and response contents come from a cycle-count model: the ack lands on
// edge k after cyc rises, the abort on edge TO, and whichever is first
// (ack on a tie) ends the transaction.
module tb_wb_uart_initiator;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int TO    = 64;
  localparam int NOACK = 1000000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  wb_uart_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_uart_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.o_cmd_ready, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr,
            bus.o_wb_data, bus.o_wb_sel, bus.o_rsp_valid, bus.o_rsp_data,
            bus.o_rsp_err, bus.o_busy};
  endfunction

  // One full command/bus/response exchange. ack_d < 0 means the responder
  // never acks; otherwise ack comes ack_d edges after the unstalled edge.
  task automatic txn(input string nm, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [3:0] sel,
                     input int n_stall, input int ack_d, input logic [DW-1:0] rdata,
                     input bit spur, input bit extra, input int rdy_wait);
    int ack_k, exp_cyc, exp_stb, cyc_n, stb_n, k;
    bit exp_err, stable, early, hold_ok;
    logic [DW-1:0] exp_data;

    ack_k    = (ack_d < 0) ? NOACK : n_stall + 1 + ack_d;
    exp_cyc  = (ack_k < TO) ? ack_k : TO;
    exp_err  = (ack_k > TO);
    exp_stb  = (n_stall + 1 < TO) ? n_stall + 1 : TO;
    exp_data = (exp_err || we) ? '0 : rdata;

    @(negedge clk);
    chk({nm, ".cmd_ready"}, bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = wdata;
    bus.i_cmd_sel   = sel;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = $urandom;
    chk({nm, ".start"}, {bus.o_wb_cyc, bus.o_wb_stb, bus.o_busy, bus.o_cmd_ready}, 4'b1110);
    chk({nm, ".fields"}, {bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel},
        {we, addr, wdata, sel});

    cyc_n = 1; stb_n = 1; stable = 1; early = 0; k = 0;
    while (bus.o_wb_cyc === 1'b1 && k < TO + 8) begin
      k++;
      bus.i_wb_stall = (k <= n_stall);
      bus.i_wb_ack   = (k == ack_k) || (spur && k == 1 && n_stall > 0);
      bus.i_wb_data  = (k == ack_k) ? rdata : DW'($urandom);
      @(posedge clk); #1;
      if (bus.o_wb_cyc === 1'b1) cyc_n++;
      if (bus.o_wb_stb === 1'b1) begin
        stb_n++;
        if ({bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel} !== {we, addr, wdata, sel})
          stable = 0;
      end
      if (bus.o_wb_cyc === 1'b1 && bus.o_rsp_valid !== 1'b0) early = 1;
    end
    bus.i_wb_stall = 1'b0;
    bus.i_wb_ack   = extra;

    chk({nm, ".cyc_cycles"}, cyc_n, exp_cyc);
    chk({nm, ".stb_cycles"}, stb_n, exp_stb);
    chk({nm, ".stable_early"}, {stable, early}, 2'b10);
    chk({nm, ".rsp"}, {bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err, bus.o_busy, bus.o_cmd_ready},
        {1'b1, exp_data, exp_err, 1'b1, 1'b0});

    hold_ok = 1;
    for (int i = 0; i < rdy_wait; i++) begin
      bus.i_rsp_ready = 1'b0;
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_addr  = AW'($urandom);
      @(posedge clk); #1;
      bus.i_wb_ack = 1'b0;
      if ({bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err, bus.o_cmd_ready, bus.o_wb_cyc}
          !== {1'b1, exp_data, exp_err, 1'b0, 1'b0})
        hold_ok = 0;
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    bus.i_wb_ack    = 1'b0;
    chk({nm, ".hold"}, hold_ok, 1);
    chk({nm, ".done"}, {bus.o_rsp_valid, bus.o_busy, bus.o_cmd_ready, bus.o_wb_cyc}, 4'b0010);
  endtask

  initial begin
    logic sawv;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0;
    bus.i_cmd_valid = 0; bus.i_cmd_we = 0; bus.i_cmd_addr = '0;
    bus.i_cmd_data = '0; bus.i_cmd_sel = '0;
    bus.i_wb_stall = 0; bus.i_wb_ack = 0; bus.i_wb_data = '0; bus.i_rsp_ready = 0;

    // mid-cycle reset at power-up
    #2 rst = 1'b1;
    #1 chk("por.outs", all_outs(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk("por.ready", {bus.o_cmd_ready, bus.o_busy}, 2'b10);

    // directed cases
    txn("wr0", 1'b1, 2'd0, 32'h0000_0001, 4'hF, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    txn("rd_stall", 1'b0, 2'd2, 32'h1234_5678, 4'hF, 3, 1, 32'hA5A5_005A, 1, 1, 0);
    txn("rd_timeout", 1'b0, 2'd1, 32'h0, 4'h3, 0, -1, 32'h0, 0, 0, 1);
    txn("after_to", 1'b0, 2'd3, 32'h0, 4'hF, 0, 0, 32'h0BAD_F00D, 0, 0, 0);
    txn("bp10", 1'b0, 2'd1, 32'h0, 4'hC, 0, 2, 32'h5555_AAAA, 0, 0, 10);
    txn("ack_at_to", 1'b0, 2'd2, 32'h0, 4'hF, 0, TO - 1, 32'hCAFE_0001, 0, 0, 0);
    txn("ack_past_to", 1'b0, 2'd2, 32'h0, 4'hF, 0, TO, 32'hCAFE_0002, 0, 0, 0);
    txn("stall_forever", 1'b1, 2'd3, 32'hFFFF_FFFF, 4'h1, 200, -1, 32'h0, 1, 0, 2);

    // reset during WAIT, then a late ack must not produce a response
    @(negedge clk);
    bus.i_cmd_valid = 1; bus.i_cmd_we = 1; bus.i_cmd_addr = 2'd3;
    bus.i_cmd_data = 32'h8765_4321; bus.i_cmd_sel = 4'hF;
    @(posedge clk); #1 bus.i_cmd_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk("rst_wait.outs", all_outs(), '0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_wait.ready", {bus.o_cmd_ready, bus.o_busy}, 2'b10);
    bus.i_wb_ack = 1'b1; bus.i_wb_data = 32'h1111_2222;
    sawv = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.o_rsp_valid !== 1'b0 || bus.o_wb_cyc !== 1'b0) sawv = 1'b1;
    end
    bus.i_wb_ack = 1'b0;
    chk("late_ack.no_rsp", {sawv, bus.o_cmd_ready, bus.o_busy}, 3'b010);

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      txn("rand", 1'($urandom), AW'($urandom), DW'($urandom), 4'($urandom),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), DW'($urandom),
          1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
